// File: rtl/mips_pkg.sv
// mips_pkg: types shared by the memory debug-port helpers
// (dump FSM states, word geometry, byte-lane index).
package mips_pkg;

   localparam int WORD_BYTES = 4;

   typedef logic [$clog2(WORD_BYTES)-1:0] lane_idx_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LAST,
      S_OUT,
      S_DONE
   } dump_state_t;

endpackage

// File: rtl/mem_dump_reader_if.sv
// mem_dump_reader_if: debug byte port of MEM.bytes plus the
// valid/ready word stream produced by the dump reader.
interface mem_dump_reader_if #(
   parameter int ADDR_W = 32
);

   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;

   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_last;

   modport master (
      output mem_rd,
      output mem_addr,
      input  mem_rdata,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_addr,
      output out_last
   );

   modport slave (
      input  mem_rd,
      input  mem_addr,
      output mem_rdata,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_addr,
      input  out_last
   );

endinterface

// File: rtl/mem_word_assembler.sv
// mem_word_assembler: four byte-lane capture register that
// rebuilds a little-endian word one lane at a time.
module mem_word_assembler
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        we,
   input  lane_idx_t   lane,
   input  logic [7:0]  din,
   output logic [31:0] word
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word <= '0;
      end else if (clr) begin
         word <= '0;
      end else if (we) begin
         word[{lane, 3'b000} +: 8] <= din;
      end
   end

endmodule

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: walks a word range of MEM.bytes and streams LE words.
// Optional running checksum port when MEM_DUMP_CHECKSUM_EN is defined.
module mem_dump_reader
   import mips_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic              busy,
   output logic              done,
`ifdef MEM_DUMP_CHECKSUM_EN
   output logic [31:0]       checksum,
`endif
   mem_dump_reader_if.master bus
);

   dump_state_t       state;
   dump_state_t       nxt;
   lane_idx_t         idx;
   lane_idx_t         cap_lane;
   logic [ADDR_W-1:0] word_addr;
   logic [CNT_W-1:0]  remaining;
   logic [31:0]       word;
   logic              accept;
   logic              hs;
   logic              last_word;
   logic              cap_we;

   assign accept    = (state == S_IDLE) && start;
   assign hs        = (state == S_OUT) && bus.out_ready;
   assign last_word = (remaining == CNT_W'(1));
   assign cap_lane  = idx - 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               nxt = (word_count == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            if (idx == lane_idx_t'(WORD_BYTES - 1)) begin
               nxt = S_LAST;
            end
         end
         S_LAST: nxt = S_OUT;
         S_OUT: begin
            if (bus.out_ready) begin
               nxt = last_word ? S_DONE : S_READ;
            end
         end
         S_DONE: nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // Lane idx-1 receives the byte read on the previous cycle.
   always_comb begin
      busy          = (state != S_IDLE);
      done          = (state == S_DONE);
      bus.mem_rd    = (state == S_READ);
      bus.out_valid = (state == S_OUT);
      cap_we        = ((state == S_READ) && (idx != '0))
                    || (state == S_LAST);
   end

   assign bus.mem_addr = word_addr + ADDR_W'(idx);
   assign bus.out_data = word;
   assign bus.out_addr = word_addr;
   assign bus.out_last = last_word;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx       <= '0;
         word_addr <= '0;
         remaining <= '0;
      end else if (accept) begin
         idx       <= '0;
         word_addr <= base_addr & ~ADDR_W'(WORD_BYTES - 1);
         remaining <= word_count;
      end else begin
         if (state == S_READ) begin
            idx <= idx + 1'b1;
         end
         if (hs) begin
            remaining <= remaining - 1'b1;
            word_addr <= word_addr + ADDR_W'(WORD_BYTES);
         end
      end
   end

   mem_word_assembler u_asm (
      .clk   (clk),
      .reset (reset),
      .clr   (accept),
      .we    (cap_we),
      .lane  (cap_lane),
      .din   (bus.mem_rdata),
      .word  (word)
   );

`ifdef MEM_DUMP_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         checksum <= '0;
      end else if (accept) begin
         checksum <= '0;
      end else if (hs) begin
         checksum <= checksum + word;
      end
   end
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: scoreboard bench for mem_dump_reader
// with a byte memory model on the debug port.
module tb_mem_dump_reader;

   typedef struct {
      logic [31:0] d;
      logic [31:0] a;
      logic        l;
   } exp_t;

   logic        clk = 0;
   logic        reset = 0;
   logic        start = 0;
   logic [31:0] base_addr = '0;
   logic [15:0] word_count = '0;
   logic        busy;
   logic        done;
`ifdef MEM_DUMP_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   mem_dump_reader_if #(.ADDR_W(32)) bus ();

   mem_dump_reader #(.ADDR_W(32), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
`ifdef MEM_DUMP_CHECKSUM_EN
      .checksum   (checksum),
`endif
      .bus        (bus.master)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [256];
   exp_t        exp_q [$];
   logic [31:0] rd_q [$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          first_v = -1;
   int          last_hs = 0;
   int          hs_cnt = 0;
   int          rd_seen = 0;
   bit          stall_mode = 0;
   int          stall_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
   end

   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!stall_mode) begin
            bus.out_ready = 1'b1;
            stall_cnt = 0;
         end else if (bus.out_valid && stall_cnt < 3) begin
            bus.out_ready = 1'b0;
            stall_cnt++;
         end else if (bus.out_valid) begin
            bus.out_ready = 1'b1;
            stall_cnt = 0;
         end else begin
            bus.out_ready = 1'b0;
            stall_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         if (bus.mem_rd) begin
            rd_seen++;
            chk("rd_pending", rd_q.size() != 0, 1);
            if (rd_q.size() != 0) chk("rd_addr", bus.mem_addr, rd_q.pop_front());
         end
         if (bus.out_valid) begin
            if (first_v < 0) first_v = cyc;
            chk("out_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               chk("out_data", bus.out_data, exp_q[0].d);
               chk("out_addr", bus.out_addr, exp_q[0].a);
               chk("out_last", bus.out_last, exp_q[0].l);
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  last_hs = cyc + 1;
                  hs_cnt++;
               end
            end
         end
      end
   end

   task automatic load_exp(input logic [31:0] base, input logic [15:0] n,
                           output logic [31:0] sum);
      logic [31:0] wa;
      logic [31:0] ra;
      exp_t        e;
      wa  = base & 32'hFFFF_FFFC;
      sum = '0;
      for (int i = 0; i < int'(n); i++) begin
         for (int b = 0; b < 4; b++) begin
            ra = wa + 32'(b);
            e.d[8*b +: 8] = mem[ra[7:0]];
            rd_q.push_back(ra);
         end
         e.a = wa;
         e.l = (i == int'(n) - 1);
         sum = sum + e.d;
         exp_q.push_back(e);
         wa = wa + 32'd4;
      end
   endtask

   task automatic run_dump(input logic [31:0] base, input logic [15:0] n,
                           input bit stall, input bit poke);
      logic [31:0] sum;
      int          s;
      int          r0;
      bit          got;
      load_exp(base, n, sum);
      stall_mode = stall;
      first_v = -1;
      r0 = rd_seen;
      @(posedge clk);
      #1;
      start = 1;
      base_addr = base;
      word_count = n;
      @(posedge clk);
      #1;
      s = cyc;
      start = 0;
      base_addr = '0;
      word_count = '0;
      if (poke) begin
         repeat (2) @(posedge clk);
         #1;
         start = 1;
         base_addr = 32'h80;
         word_count = 16'd7;
         @(posedge clk);
         #1;
         start = 0;
      end
      got = 0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            break;
         end
      end
      chk("done_seen", got, 1);
      if (got) begin
         chk("done_cyc", cyc, (n == 0) ? s : last_hs);
         chk("busy_in_done", busy, 1);
         if (n == 0) chk("no_valid", first_v, -1);
         else chk("latency", first_v - s, 5);
         chk("rd_total", rd_seen - r0, 4 * int'(n));
         chk("exp_left", exp_q.size(), 0);
`ifdef MEM_DUMP_CHECKSUM_EN
         chk("checksum", checksum, sum);
`endif
         @(negedge clk);
         chk("done_pulse", done, 0);
         chk("busy_after", busy, 0);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd"}, bus.mem_rd, 0);
      chk({tag, "_addr"}, bus.mem_addr, 0);
      chk({tag, "_valid"}, bus.out_valid, 0);
      chk({tag, "_data"}, bus.out_data, 0);
      chk({tag, "_oaddr"}, bus.out_addr, 0);
      chk({tag, "_last"}, bus.out_last, 0);
`ifdef MEM_DUMP_CHECKSUM_EN
      chk({tag, "_csum"}, checksum, 0);
`endif
   endtask

   task automatic set_word(input int a, input logic [31:0] w);
      for (int b = 0; b < 4; b++) mem[(a + b) % 256] = w[8*b +: 8];
   endtask

   task automatic reset_mid_dump();
      logic [31:0] sum;
      int          h0;
      bit          got;
      load_exp(32'h40, 16'd3, sum);
      stall_mode = 0;
      h0 = hs_cnt;
      @(posedge clk);
      #1;
      start = 1;
      base_addr = 32'h40;
      word_count = 16'd3;
      @(posedge clk);
      #1;
      start = 0;
      got = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (hs_cnt > h0) begin
            got = 1;
            break;
         end
      end
      chk("rst_first_hs", got, 1);
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      #1;
      chk_zero("rst_mid");
      exp_q.delete();
      rd_q.delete();
      @(posedge clk);
      #1;
      reset = 1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      set_word(32, 32'h0000_0001);
      #1;
      chk_zero("reset");
      repeat (3) @(posedge clk);
      #1;
      reset = 1;

      run_dump(32'd32, 16'd1, 0, 0);

      set_word(32, 32'h0000_0001);
      set_word(36, 32'h0000_0004);
      set_word(40, 32'hFFFF_FFFC);
      set_word(44, 32'h0000_0005);
      run_dump(32'd34, 16'd4, 0, 0);
      run_dump(32'd32, 16'd4, 1, 0);
      run_dump(32'd32, 16'd0, 0, 0);
      run_dump(32'd32, 16'd4, 0, 1);

      set_word(252, 32'hA1B2_C3D4);
      set_word(0, 32'h1122_3344);
      run_dump(32'hFFFF_FFFC, 16'd2, 0, 0);

      reset_mid_dump();
      run_dump(32'h10, 16'd2, 0, 0);
      run_dump(32'h77, 16'd5, 1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Read-side counterpart to the byte-wide program/data loader: after a run, walks a word range of the pipeline's byte-addressed memory (`MEM.bytes`), reassembles little-endian 32-bit words and streams them out over a valid/ready port. It sits beside the MIPS pipeline on the memory's debug byte port, for post-run result checking and image dumps.

## Interface
- `ADDR_W`, 32, byte address width
- `CNT_W`, 16, width of word-count field
- `clk`  input  1  single clock, all logic on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `start`  input  1  one-cycle request; sampled only in IDLE
- `base_addr`  input  ADDR_W  first byte address; bits [1:0] forced to 0
- `word_count`  input  CNT_W  number of words to dump
- `busy`  output  1  high from accepted start until done
- `done`  output  1  one-cycle pulse after final word handshake (or zero-count start)
- `mem_rd`  output  1  byte read strobe
- `mem_addr`  output  ADDR_W  byte address of current read
- `mem_rdata`  input  8  byte data, valid exactly one cycle after `mem_rd`
- `out_valid`  output  1  `out_data` holds an assembled word
- `out_ready`  input  1  consumer accepts word when high with `out_valid`
- `out_data`  output  32  assembled word, byte at lowest address in [7:0]
- `out_addr`  output  ADDR_W  byte address of the word's byte 0
- `out_last`  output  1  high with the final word of the range
- `checksum`  output  32  only with `MEM_DUMP_CHECKSUM_EN`

## Operation
- States: IDLE, READ, LAST, OUT, DONE.
- IDLE: `start`=1 latches aligned base and count; count 0 → DONE; else → READ with byte index 0.
- READ: `mem_rd`=1, `mem_addr`=word_addr+idx; idx increments each cycle; after idx 3 → LAST.
- Captures: `mem_rdata` written into byte lane idx-1 on the cycle after each read; LAST captures lane 3, `mem_rd`=0, → OUT.
- OUT: `out_valid`=1; `out_data`/`out_addr`/`out_last` stable until `out_ready`. On handshake: remaining-count decrements; word_addr += 4; if it was the last word → DONE, else → READ.
- DONE: `done`=1 for one cycle, `busy`=0 next cycle, → IDLE.
- `start` while not IDLE is ignored.
- Address arithmetic modulo 2^ADDR_W; range crossing the top wraps to 0 without error.
- Reset (any state, mid-word included): IDLE, all outputs 0, partial word discarded, `checksum` 0.

## Timing
- Start sampled at edge E0; `mem_rd` high during cycles after E0..E3; `out_valid` rises after E5 (5-cycle latency to first word).
- Per word with `out_ready` held high: 6 cycles (4 READ, 1 LAST, 1 OUT).
- `done` asserts the cycle after the final handshake edge; zero-count start → `done` the cycle after E0, no `mem_rd`, no `out_valid`.
- `out_valid` never drops without a handshake.

## Configuration
- `MEM_DUMP_CHECKSUM_EN` defined: `checksum` port present; cleared on accepted start; on each handshake adds `out_data` modulo 2^32; holds final value after `done` until next start or reset.
- Undefined: no `checksum` port, no adder; all other behaviour identical.

## Structure
- Shared package `mips_pkg`: state enum `dump_state_t`, `WORD_BYTES`=4, byte-lane index type.
- Sub-module `mem_word_assembler`: 4-lane capture register with lane-select and clear; FSM, counters, checksum stay in top.

## Test plan
- Memory bytes 32..35 = 01,00,00,00; start base 32, count 1, `out_ready`=1 → `out_data`=0x00000001, `out_addr`=32, `out_last`=1, `out_valid` 5 cycles after start, `done` pulse next cycle.
- Bytes 32..47 = 0x1, 0x4, 0xFFFFFFFC, 0x5 (LE); base 34, count 4 → words in order from addr 32, 36, 40, 44; with checksum macro `checksum`=0x00000006.
- Same range, `out_ready` low 3 cycles per word → `out_data` stable while stalled, 4 words exactly, no duplicate or skipped reads.
- count 0 → `done` one cycle after start, `mem_rd` never asserted; start asserted while busy → ignored, output sequence unchanged.
- base 0xFFFFFFFC, count 2 → second word read from addresses 0..3, `out_addr`=0.
- `reset` low during READ of word 2 → all outputs 0 immediately; new start after release dumps from fresh base correctly.
